// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants for the display scan controller: glyphs, pin polarity, FSM encoding.
package disp_scan_ctrl_pkg;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Board pins are active-low
  localparam logic [6:0] SEG_PIN_OFF = 7'h7F;
  localparam logic       DP_PIN_OFF  = 1'b1;
  localparam logic       AN_ON       = 1'b0;
  localparam logic       AN_OFF      = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/disp_scan_ctrl_hex7seg_dec.sv
// Hex nibble to active-high 7-segment glyph (lowercase b and d).
module hex7seg_dec
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered display value.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking.
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       load,
  input  logic [4*N_DIG-1:0]         data_in,
  input  logic [N_DIG-1:0]           dp_in,
  output logic [6:0]                 seg_out,
  output logic                       dp_out,
  output logic [N_DIG-1:0]           an_out,
  output logic [$clog2(N_DIG)-1:0]   dig_idx,
  output logic                       frame_done
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned DigW = $clog2(N_DIG);
  localparam logic [CntW-1:0] CntLast   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
  localparam logic [DigW-1:0] DigLast   = DigW'(N_DIG - 1);

  typedef logic [N_DIG-1:0][3:0] nib_arr_t;

  scan_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DigW-1:0]   dig_q, dig_d;
  nib_arr_t          disp_q, disp_d, pend_q, pend_d;
  logic [N_DIG-1:0]  disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic              pend_vld_q, pend_vld_d;
  logic              commit;

  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [N_DIG-1:0]  an_q, an_d;
  logic              fd_q, fd_d;

  logic [3:0]        cur_nib;
  logic [6:0]        cur_glyph;
  logic [N_DIG-1:0]  lz_mask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dig_d      = dig_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    commit     = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        dig_d = '0;
        if (en) begin
          state_d = StBlank;
          commit  = 1'b1;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) state_d = StShow;
        cnt_d = cnt_q + 1'b1;
      end
      StShow: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StBlank;
          if (dig_q == DigLast) begin
            dig_d  = '0;
            commit = 1'b1;
          end else begin
            dig_d = dig_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!en) begin
      state_d = StIdle;
      cnt_d   = '0;
      dig_d   = '0;
      commit  = 1'b0;
    end

    // Commit uses the pending value from before this cycle's load, so a load on the
    // boundary lands in pending and waits for the following frame.
    if (commit && pend_vld_q) begin
      disp_d     = pend_q;
      disp_dp_d  = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (load) begin
      pend_d     = data_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

`ifdef DISP_SCAN_LZB_EN
  always_comb begin : lzb
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (disp_d[k] == 4'h0);
      lz_mask[k] = upper_zero && !disp_dp_d[k];
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign cur_nib = disp_d[dig_d];

  hex7seg_dec u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_glyph)
  );

  // Outputs are computed from next-state so the registered pins line up with state_q.
  always_comb begin
    an_d  = {N_DIG{AN_OFF}};
    seg_d = SEG_PIN_OFF;
    dp_d  = DP_PIN_OFF;
    fd_d  = 1'b0;
    if (state_d != StIdle) begin
      seg_d = lz_mask[dig_d] ? SEG_PIN_OFF : ~cur_glyph;
      dp_d  = ~disp_dp_d[dig_d];
    end
    if (state_d == StShow) begin
      an_d[dig_d] = AN_ON;
      fd_d        = (cnt_d == CntLast) && (dig_d == DigLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dig_q      <= '0;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_PIN_OFF;
      dp_q       <= DP_PIN_OFF;
      an_q       <= {N_DIG{AN_OFF}};
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;
  assign dig_idx    = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl with N_DIG=4, CLK_DIV=8, BLANK_CYC=2.
module tb_disp_scan_ctrl;

  localparam int NDig  = 4;
  localparam int Div   = 8;
  localparam int Blank = 2;
  localparam int Frame = NDig * Div;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  dp;
  } frame_t;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    logic [3:0]  dp;
  } ld_t;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  dig_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t frm_q[$];
  ld_t    ld_q[$];

  disp_scan_ctrl #(
    .N_DIG     (NDig),
    .CLK_DIV   (Div),
    .BLANK_CYC (Blank)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .dig_idx    (dig_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Pin value expected for digit d of value v
  function automatic logic [6:0] exp_seg(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic blank;
    blank = (d > 0) && (dp[d] == 1'b0) && ((v >> (4 * d)) == 16'h0);
`ifndef DISP_SCAN_LZB_EN
    blank = 1'b0;
`endif
    return blank ? 7'h7F : ~glyph(v[4*d +: 4]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string tag);
    n_checks += 4;
    if (seg_out !== 7'h7F) begin
      n_fail++; $display("FAIL %s seg_out got=%h exp=7f", tag, seg_out);
    end
    if (an_out !== 4'hF) begin
      n_fail++; $display("FAIL %s an_out got=%h exp=f", tag, an_out);
    end
    if (dig_idx !== 2'd0) begin
      n_fail++; $display("FAIL %s dig_idx got=%0d exp=0", tag, dig_idx);
    end
    if (frame_done !== 1'b0 || dp_out !== 1'b1) begin
      n_fail++; $display("FAIL %s fd/dp got=%b%b exp=01", tag, frame_done, dp_out);
    end
  endtask

  // DUT must be in the first cycle of a frame; each frame pops one scoreboard entry.
  task automatic check_run(input int n);
    frame_t cur;
    ld_t    ld;
    cur = '{v: 16'h0, dp: 4'h0};
    for (int i = 0; i < n; i++) begin
      int c, d;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      c = i % Div;
      d = (i / Div) % NDig;
      if (i % Frame == 0) begin
        n_checks++;
        if (frm_q.size() == 0) begin
          n_fail++; $display("FAIL scoreboard empty at i=%0d got=0 exp=1", i);
        end else begin
          cur = frm_q.pop_front();
        end
      end
      e_an  = (c < Blank) ? 4'hF : ~(4'b0001 << d);
      e_seg = exp_seg(cur.v, cur.dp, d);
      n_checks += 5;
      if (an_out !== e_an) begin
        n_fail++; $display("FAIL an_out i=%0d got=%h exp=%h", i, an_out, e_an);
      end
      if (seg_out !== e_seg) begin
        n_fail++; $display("FAIL seg_out i=%0d got=%h exp=%h val=%h", i, seg_out, e_seg, cur.v);
      end
      if (dp_out !== ~cur.dp[d]) begin
        n_fail++; $display("FAIL dp_out i=%0d got=%b exp=%b", i, dp_out, ~cur.dp[d]);
      end
      if (dig_idx !== 2'(d)) begin
        n_fail++; $display("FAIL dig_idx i=%0d got=%0d exp=%0d", i, dig_idx, d);
      end
      if (frame_done !== (d == NDig - 1 && c == Div - 1)) begin
        n_fail++; $display("FAIL frame_done i=%0d got=%b", i, frame_done);
      end
      load = 1'b0;
      if (ld_q.size() > 0 && ld_q[0].cyc == i) begin
        ld      = ld_q.pop_front();
        load    = 1'b1;
        data_in = ld.v;
        dp_in   = ld.dp;
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; data_in = 16'h0; dp_in = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark("reset");
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    load = 1'b1; data_in = 16'h12AF; dp_in = 4'h0;
    step();
    load = 1'b0;
    check_dark("idle_after_load");
    en = 1'b1;
    step();
    frm_q.push_back('{v: 16'h12AF, dp: 4'h0});
    frm_q.push_back('{v: 16'h12AF, dp: 4'h0});
    check_run(2 * Frame);
  endtask

  task automatic test_update();
    frm_q.push_back('{v: 16'h12AF, dp: 4'h0});
    ld_q.push_back('{cyc: 11, v: 16'h3456, dp: 4'h0});
    frm_q.push_back('{v: 16'h3456, dp: 4'h0});
    check_run(2 * Frame);
  endtask

  // Last in-frame load wins; a boundary load waits one frame behind the older pending.
  task automatic test_back_to_back();
    frm_q.push_back('{v: 16'h3456, dp: 4'h0});
    ld_q.push_back('{cyc: 5, v: 16'h1111, dp: 4'h0});
    ld_q.push_back('{cyc: 16, v: 16'h5A5A, dp: 4'h0});
    ld_q.push_back('{cyc: Frame - 1, v: 16'h789B, dp: 4'h0});
    frm_q.push_back('{v: 16'h5A5A, dp: 4'h0});
    frm_q.push_back('{v: 16'h789B, dp: 4'h0});
    check_run(3 * Frame);
  endtask

  task automatic test_en_drop_lzb_dp();
    frm_q.push_back('{v: 16'h789B, dp: 4'h0});
    ld_q.push_back('{cyc: 10, v: 16'h0050, dp: 4'h0});
    check_run(2 * Div + 4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark("en_drop");
    end
    en = 1'b1;
    step();
    frm_q.push_back('{v: 16'h0050, dp: 4'h0});
    ld_q.push_back('{cyc: 20, v: 16'h0000, dp: 4'h0});
    frm_q.push_back('{v: 16'h0000, dp: 4'h0});
    ld_q.push_back('{cyc: Frame + 20, v: 16'h12AF, dp: 4'b0100});
    frm_q.push_back('{v: 16'h12AF, dp: 4'b0100});
    check_run(3 * Frame);
  endtask

  task automatic test_rst_mid();
    load = 1'b1; data_in = 16'h1234; dp_in = 4'hF;
    step();
    load = 1'b0;
    rst  = 1'b1;
    step();
    check_dark("rst_mid");
    rst = 1'b0;
    step();
    frm_q.push_back('{v: 16'h0000, dp: 4'h0});
    check_run(Frame);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_update();
    test_back_to_back();
    test_en_drop_lzb_dp();
    test_rst_mid();
    n_checks++;
    if (frm_q.size() != 0 || ld_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard leftover got=%0d exp=0", frm_q.size() + ld_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
